// File: rtl/fb_port_arbiter.sv
// Framebuffer port A arbiter: two round-robin write requesters with a
// bounded burst length, plus a whole-buffer fill engine.
module fb_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FB_DEPTH   = 4096,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_data,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FILL} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int FA_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;

  state_t                state, state_nxt;
  logic [BC_W-1:0]       burst_cnt;
  logic [FA_W-1:0]       fill_addr;
  logic                  last_r1;     // 1 = r1 was served last
  logic                  fill_pend;   // accepted fill not yet started
  logic [DATA_WIDTH-1:0] fill_val;

  logic  beat, beat_r1, burst_wrap, ptr_set, ptr_val;
  logic  fill_wr, fill_last, fill_acc;
  beat_t src;

  assign fill_acc = fill_start && !fill_busy;
  assign src      = beat_r1 ? beat_t'({r1_addr, r1_data}) : beat_t'({r0_addr, r0_data});

  // Next-state, beat qualification and burst/fill terminal decisions
  always_comb begin
    state_nxt  = state;
    beat       = 1'b0;
    beat_r1    = 1'b0;
    burst_wrap = 1'b0;
    ptr_set    = 1'b0;
    ptr_val    = last_r1;
    fill_wr    = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_pend)                       state_nxt = FILL;
        else if (r0_req && (!r1_req || last_r1)) state_nxt = GRANT0;
        else if (r1_req)                     state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!r0_req) begin
          state_nxt = IDLE;
          ptr_set   = 1'b1;
          ptr_val   = 1'b0;
        end else begin
          beat = 1'b1;
          if (burst_cnt == BC_W'(MAX_BURST - 1)) begin
            // yield only if someone else is waiting
            if (r1_req || fill_pend) begin
              state_nxt = IDLE;
              ptr_set   = 1'b1;
              ptr_val   = 1'b0;
            end else begin
              burst_wrap = 1'b1;
            end
          end
        end
      end
      GRANT1: begin
        if (!r1_req) begin
          state_nxt = IDLE;
          ptr_set   = 1'b1;
          ptr_val   = 1'b1;
        end else begin
          beat    = 1'b1;
          beat_r1 = 1'b1;
          if (burst_cnt == BC_W'(MAX_BURST - 1)) begin
            if (r0_req || fill_pend) begin
              state_nxt = IDLE;
              ptr_set   = 1'b1;
              ptr_val   = 1'b1;
            end else begin
              burst_wrap = 1'b1;
            end
          end
        end
      end
      FILL: begin
        fill_wr = 1'b1;
        if (fill_addr == FA_W'(FB_DEPTH - 1)) begin
          fill_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered grants
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
    end else begin
      state  <= state_nxt;
      r0_gnt <= (state_nxt == GRANT0);
      r1_gnt <= (state_nxt == GRANT1);
    end
  end

  // Burst/fill counters, round-robin pointer and fill bookkeeping
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
      fill_addr <= '0;
      last_r1   <= 1'b1;
      fill_pend <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      fill_val  <= '0;
    end else begin
      burst_cnt <= (beat && !burst_wrap) ? burst_cnt + 1'b1 : '0;
      if (state == FILL) begin
        if (!fill_last) fill_addr <= fill_addr + 1'b1;
      end else begin
        fill_addr <= '0;
      end
      if (ptr_set) last_r1 <= ptr_val;
      if (fill_acc) begin
        fill_pend <= 1'b1;
        fill_val  <= fill_value;
      end else if (state == IDLE && fill_pend) begin
        fill_pend <= 1'b0;
      end
      if (fill_acc)       fill_busy <= 1'b1;
      else if (fill_done) fill_busy <= 1'b0;
      fill_done <= fill_last;
    end
  end

  // Registered RAM port drive; address/data hold when idle
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ram_address      <= '0;
      ram_data_out     <= '0;
      ram_write_enable <= 1'b0;
      ram_clk_enable   <= 1'b0;
    end else begin
      ram_write_enable <= beat | fill_wr;
      ram_clk_enable   <= beat | fill_wr;
      if (beat) begin
        ram_address  <= src.addr;
        ram_data_out <= src.data;
      end else if (fill_wr) begin
        ram_address  <= ADDR_WIDTH'(fill_addr);
        ram_data_out <= fill_val;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: RAM writes checked via scoreboard.
module tb_fb_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_data = '0, r1_data = '0;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_value = '0;
  logic          r0_gnt, r1_gnt, fill_busy, fill_done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out;
  logic          ram_write_enable, ram_clk_enable;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t sb[$];
  wr_t e;

  fb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_DEPTH(4096), .MAX_BURST(16)) dut (
    .clk_in(clk_in), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_data(r1_data),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable)
  );

  always #5 clk_in = ~clk_in;

  // cycle index used to check one-cycle write latency
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back('{cyc + 1, a, d});
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // RAM port monitor: every write must match the scoreboard head
  always @(negedge clk_in) begin
    if (ram_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_write", {31'd0, ram_write_enable}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_cyc", cyc, e.c);
        chk("wr_addr", {20'd0, ram_address}, {20'd0, e.a});
        chk("wr_data", {24'd0, ram_data_out}, {24'd0, e.d});
        chk("wr_ce", {31'd0, ram_clk_enable}, 32'd1);
      end
    end else begin
      chk("ce_idle", {31'd0, ram_clk_enable}, 32'd0);
    end
  end

  initial begin
    logic g0, g1;

    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_async", {r0_gnt, r1_gnt, fill_busy, fill_done, ram_write_enable, ram_clk_enable,
                      ram_address, ram_data_out}, 32'd0);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_hold", {r0_gnt, r1_gnt, fill_busy, fill_done, ram_write_enable, ram_clk_enable,
                     ram_address, ram_data_out}, 32'd0);
    reset = 1'b1;
    step(); step();

    // single requester, three beats
    for (int k = 0; k < 6; k++) begin
      r0_req  = (k < 4);
      r0_addr = AW'(12'h00F + k);
      r0_data = DW'(8'hA0 + k);
      @(negedge clk_in);
      chk("a_gnt", {30'd0, r0_gnt, r1_gnt}, (k >= 1 && k <= 4) ? 32'd2 : 32'd0);
      if (k >= 1 && k <= 3) push(r0_addr, r0_data);
      step();
    end
    step();
    chk("a_drain", sb.size(), 0);

    // both requesters from reset release: alternate 16-beat bursts
    reset = 1'b0;
    r0_req = 1'b1;
    r1_req = 1'b1;
    step(); step();
    reset = 1'b1;
    for (int k = 0; k <= 53; k++) begin
      r0_req  = (k < 52);
      r1_req  = (k < 52);
      r0_addr = AW'(12'h100 + k);
      r0_data = DW'(k);
      r1_addr = AW'(12'h200 + k);
      r1_data = DW'(8'h80 + k);
      @(negedge clk_in);
      g0 = (k >= 1 && k <= 16) || (k >= 35 && k <= 50);
      g1 = (k >= 18 && k <= 33) || (k == 52);
      chk("b_gnt", {30'd0, r0_gnt, r1_gnt}, {30'd0, g0, g1});
      if (g0 && k < 52) push(r0_addr, r0_data);
      if (g1 && k < 52) push(r1_addr, r1_data);
      step();
    end
    step();
    chk("b_drain", sb.size(), 0);

    // r1 alone for 40 beats: burst counter wraps without a gap
    for (int k = 0; k <= 42; k++) begin
      r1_req  = (k <= 40);
      r1_addr = AW'(12'h400 + k);
      r1_data = DW'(8'h40 + k);
      @(negedge clk_in);
      g1 = (k >= 1 && k <= 41);
      chk("c_gnt", {30'd0, r0_gnt, r1_gnt}, {31'd0, g1});
      if (g1 && k <= 40) push(r1_addr, r1_data);
      step();
    end
    step();
    chk("c_drain", sb.size(), 0);

    // fill requested at beat 5 of an r0 burst; second request ignored
    for (int k = 0; k <= 4118; k++) begin
      r0_req     = (k <= 4116);
      r0_addr    = AW'(12'h300 + k);
      r0_data    = DW'(k ^ 8'h55);
      fill_start = (k == 5 || k == 100);
      fill_value = (k == 5) ? 8'h5C : 8'h33;
      @(negedge clk_in);
      g0 = (k >= 1 && k <= 16) || (k >= 4115 && k <= 4117);
      chk("d_gnt", {30'd0, r0_gnt, r1_gnt}, {30'd0, g0, 1'b0});
      chk("d_busy", {31'd0, fill_busy}, (k >= 6 && k <= 4114) ? 32'd1 : 32'd0);
      chk("d_done", {31'd0, fill_done}, (k == 4114) ? 32'd1 : 32'd0);
      if (g0 && k <= 4116) push(r0_addr, r0_data);
      if (k >= 18 && k <= 4113) push(AW'(k - 18), 8'h5C);
      step();
    end
    fill_start = 1'b0;
    step();
    chk("d_drain", sb.size(), 0);

    // reset asserted mid-fill at address 0x200
    for (int k = 0; k <= 514; k++) begin
      fill_start = (k == 0);
      fill_value = 8'h77;
      @(negedge clk_in);
      chk("e_busy", {31'd0, fill_busy}, (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 513) push(AW'(k - 2), 8'h77);
      if (k < 514) step();
    end
    fill_start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("e_rst_async", {r0_gnt, r1_gnt, fill_busy, fill_done, ram_write_enable, ram_clk_enable,
                        ram_address, ram_data_out}, 32'd0);
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      chk("e_idle", {27'd0, r0_gnt, r1_gnt, fill_busy, fill_done, ram_write_enable}, 32'd0);
      step();
    end
    chk("e_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, framebuffer port A address width.
REQ-002 Parameter DATA_WIDTH, default 8, framebuffer port A data width.
REQ-003 Parameter FB_DEPTH, default 4096, number of addresses written by a fill.
REQ-004 Parameter MAX_BURST, default 16, beats a requester may hold the port while another party waits.
REQ-005 Port clk_in, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset: 0 = reset asserted, 1 = run.
REQ-007 Ports r0_req / r1_req, input, 1 each, requester wants to write one beat per cycle while high.
REQ-008 Ports r0_addr / r1_addr, input, ADDR_WIDTH each, beat address.
REQ-009 Ports r0_data / r1_data, input, DATA_WIDTH each, beat data.
REQ-010 Ports r0_gnt / r1_gnt, output, 1 each, registered grant; a beat transfers on each cycle with rN_req=1 and rN_gnt=1.
REQ-011 Port fill_start, input, 1, single-cycle request to fill the whole framebuffer.
REQ-012 Port fill_value, input, DATA_WIDTH, fill byte, sampled in the cycle fill_start=1 is accepted.
REQ-013 Port fill_busy, output, 1, fill pending or in progress.
REQ-014 Port fill_done, output, 1, one-cycle pulse when the fill completes.
REQ-015 Ports ram_address (ADDR_WIDTH), ram_data_out (DATA_WIDTH), ram_write_enable (1), ram_clk_enable (1), outputs, registered drive of framebuffer port A.

Function
REQ-016 The block SHALL implement states IDLE, GRANT0, GRANT1 and FILL, with exactly one state active.
REQ-017 IDLE priority SHALL be: pending fill -> FILL; else one requester high -> its GRANT; else both high -> the requester not served last (round-robin pointer, reset value = r1 served last, so r0 wins first).
REQ-018 rN_gnt SHALL be 1 exactly while the state is GRANTN, so grant appears on the cycle after IDLE.
REQ-019 In GRANTN with rN_req=0, the next state SHALL be IDLE and the round-robin pointer SHALL record N.
REQ-020 In GRANTN, each transferring beat SHALL increment a burst counter that is cleared on grant entry.
REQ-021 On the MAX_BURST-th beat, if the other requester is high or a fill is pending, the next state SHALL be IDLE with the pointer recording N; otherwise the counter SHALL clear and the grant continues.
REQ-022 Each beat SHALL appear one cycle later as ram_write_enable=1, ram_clk_enable=1, with ram_address/ram_data_out equal to the beat's addr/data.
REQ-023 When no beat or fill write occurs, ram_write_enable SHALL be 0, ram_clk_enable 0, and ram_address/ram_data_out SHALL hold their last values.
REQ-024 fill_start SHALL be accepted only when fill_busy=0; it SHALL be ignored while fill_busy=1.
REQ-025 fill_busy SHALL rise the cycle after acceptance and fall the cycle after fill_done.
REQ-026 An accepted fill during a grant SHALL stay pending until the grant ends per REQ-019/REQ-021.
REQ-027 FILL SHALL issue one write per cycle to addresses 0..FB_DEPTH-1 in ascending order with the sampled fill_value, at the same one-cycle output latency.
REQ-028 During FILL, both grants SHALL be 0 and requests SHALL only be registered for arbitration afterward.
REQ-029 fill_done SHALL pulse in the cycle the write to address FB_DEPTH-1 is driven on the RAM port; the next state SHALL be IDLE.
REQ-030 The fill address counter SHALL be wide enough not to wrap before FB_DEPTH-1 and SHALL stop there.

Reset
REQ-031 While reset=0, the block SHALL go immediately, without waiting for a clock edge, to state IDLE, with all grants 0, fill_busy 0, fill_done 0, ram_write_enable 0, ram_clk_enable 0, ram_address 0, ram_data_out 0, counters 0, pointer = r1.
REQ-032 Reset asserted mid-burst or mid-fill SHALL abort the operation with no fill_done pulse; after release, the block SHALL resume from IDLE with no pending fill.

Verification
REQ-033 r0_req=1 for 3 cycles, addr 0x010..0x012, data 0xA1..0xA3 -> r0_gnt high the cycle after req; three RAM writes, each one cycle after its beat, with matching addr/data.
REQ-034 r0_req and r1_req held high from reset release -> r0 is served first for 16 beats, then a 1-cycle IDLE gap, then r1 for 16 beats, alternating.
REQ-035 r1_req held alone for 40 cycles -> uninterrupted grant and 40 consecutive writes, no IDLE gap.
REQ-036 fill_start with fill_value=0x5C during an r0 burst at beat 5 -> r0 continues to beat 16 (r0_req held); then FILL writes 0x5C to 0x000..0xFFF on 4096 consecutive cycles; fill_done pulses with the 0xFFF write; a second fill_start meanwhile is ignored.
REQ-037 reset pulled to 0 at fill address 0x200 -> outputs go to 0 asynchronously; no fill_done; after release, IDLE with no pending fill.
